rca8b_display: RTL and testbench

Result-side display driver for the 8-bit ripple-carry adder datapath. It takes the adder's 8-bit sum and carry-out as a 9-bit unsigned value (0..511) and converts it to three BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto a 4-digit common-anode seven-segment display. It sits between the adder controller's `out`/`cout` and the board display pins.

---
 rtl/rca8b_display_pkg.sv | 24 ++
 rtl/rca8b_display_seg7.sv | 26 ++
 rtl/rca8b_display.sv | 151 +++++++++++++++
 tb/tb_rca8b_display.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rca8b_display_pkg.sv
// rtl/rca8b_display_pkg.sv - shared types and constants for the rca8b display driver
package rca8b_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } conv_state_e;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [6:0] SEG_BLANK   = 7'h7F;
   localparam int         SHIFT_COUNT = 9;

   // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
   function automatic logic [11:0] dabble_adjust(input logic [11:0] w);
      logic [11:0] r;
      for (int i = 0; i < 3; i++) begin
         r[i*4 +: 4] = (w[i*4 +: 4] >= 4'd5) ? (w[i*4 +: 4] + 4'd3) : w[i*4 +: 4];
      end
      return r;
   endfunction

endpackage

// File: rtl/rca8b_display_seg7.sv
// rtl/rca8b_display_seg7.sv - BCD digit to active-low {g..a} segment decoder
module seg7_decode
   import rca8b_pkg::*;
(
   input  bcd_digit_t  digit,
   output logic [6:0]  seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/rca8b_display.sv
// rtl/rca8b_display.sv - 9-bit adder result to BCD, multiplexed onto a 4-digit seven-segment display
// Optional leading-zero blanking: define RCA8B_DISP_LEADZERO_BLANK_EN.
module rca8b_display
   import rca8b_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  sum,
   input  logic        cout,
   output logic [11:0] bcd,
   output logic        busy,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   logic [8:0]  v;
   logic [8:0]  last_v_q, last_v_d;
   logic [8:0]  shreg_q, shreg_d;
   logic [11:0] work_q, work_d;
   logic [11:0] work_adj;
   logic [3:0]  cnt_q, cnt_d;
   logic [11:0] bcd_q, bcd_d;
   logic        busy_q, busy_d;
   conv_state_e state_q, state_d;

   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [1:0]    dig_q, dig_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   bcd_digit_t    nib;
   logic [6:0]    dec_seg;

   assign v        = {cout, sum};
   assign work_adj = dabble_adjust(work_q);

   always_comb begin
      state_d  = state_q;
      last_v_d = last_v_q;
      shreg_d  = shreg_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      bcd_d    = bcd_q;
      busy_d   = busy_q;
      case (state_q)
         S_IDLE: begin
            if (v != last_v_q) begin
               last_v_d = v;
               shreg_d  = v;
               work_d   = 12'h000;
               cnt_d    = 4'd0;
               busy_d   = 1'b1;
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            work_d  = {work_adj[10:0], shreg_q[8]};
            shreg_d = {shreg_q[7:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'(SHIFT_COUNT - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            bcd_d   = work_q;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rcnt_d = rcnt_q + 1'b1;
      dig_d  = dig_q;
      if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
         rcnt_d = '0;
         dig_d  = dig_q + 2'd1;
      end
   end

   // Blank positions are fed to the decoder as 4'hF, which it renders as all-off.
   always_comb begin
      nib = 4'hF;
      case (dig_q)
         2'd0: nib = bcd_q[3:0];
         2'd1: begin
            nib = bcd_q[7:4];
`ifdef RCA8B_DISP_LEADZERO_BLANK_EN
            if (bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0) nib = 4'hF;
`endif
         end
         2'd2: begin
            nib = bcd_q[11:8];
`ifdef RCA8B_DISP_LEADZERO_BLANK_EN
            if (bcd_q[11:8] == 4'd0) nib = 4'hF;
`endif
         end
         default: nib = 4'hF;
      endcase
   end

   seg7_decode u_seg7_decode (
      .digit (nib),
      .seg   (dec_seg)
   );

   always_comb begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = dec_seg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         last_v_q <= '0;
         shreg_q  <= '0;
         work_q   <= '0;
         cnt_q    <= '0;
         bcd_q    <= 12'h000;
         busy_q   <= 1'b0;
         rcnt_q   <= '0;
         dig_q    <= 2'd0;
         an_q     <= 4'b1110;
         seg_q    <= 7'b1000000;
      end else begin
         state_q  <= state_d;
         last_v_q <= last_v_d;
         shreg_q  <= shreg_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         bcd_q    <= bcd_d;
         busy_q   <= busy_d;
         rcnt_q   <= rcnt_d;
         dig_q    <= dig_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   assign bcd  = bcd_q;
   assign busy = busy_q;
   assign an   = an_q;
   assign seg  = seg_q;
   assign dp   = 1'b1;

endmodule

// File: tb/tb_rca8b_display.sv
// tb/tb_rca8b_display.sv - self-checking bench for rca8b_display against a decimal/scan reference model
module tb_rca8b_display;

   localparam int RDIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  sum = 8'h00;
   logic        cout = 1'b0;
   logic [11:0] bcd;
   logic        busy;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int checks = 0;
   int errors = 0;
   logic [11:0] cur_bcd = 12'h000;
   logic [8:0]  last_v = 9'd0;

   rca8b_display #(.REFRESH_DIV(RDIV)) dut (
      .clk  (clk),
      .rst  (rst),
      .sum  (sum),
      .cout (cout),
      .bcd  (bcd),
      .busy (busy),
      .an   (an),
      .seg  (seg),
      .dp   (dp)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] to_bcd(input int val);
      return {4'(val / 100), 4'((val / 10) % 10), 4'(val % 10)};
   endfunction

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [6:0] exp_glyph(input logic [11:0] b, input int pos);
      int h, t, u;
      bit lz;
      h = int'(b[11:8]);
      t = int'(b[7:4]);
      u = int'(b[3:0]);
`ifdef RCA8B_DISP_LEADZERO_BLANK_EN
      lz = 1'b1;
`else
      lz = 1'b0;
`endif
      case (pos)
         0: return glyph(u);
         1: return (lz && h == 0 && t == 0) ? 7'h7F : glyph(t);
         2: return (lz && h == 0) ? 7'h7F : glyph(h);
         default: return 7'h7F;
      endcase
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [8:0] val);
      {cout, sum} = val;
   endtask

   task automatic convert(input logic [8:0] val, input string name);
      logic [11:0] exp;
      exp = to_bcd(int'(val));
      drive(val);
      step;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_capture: busy=%b expected 1", name, busy);
      end
      for (int i = 1; i <= 9; i++) begin
         step;
         checks++;
         if (busy !== 1'b1 || bcd !== cur_bcd) begin
            errors++;
            $display("FAIL %s_mid%0d: busy=%b bcd=%h expected busy=1 bcd=%h", name, i, busy, bcd, cur_bcd);
         end
      end
      step;
      checks++;
      if (busy !== 1'b0 || bcd !== exp) begin
         errors++;
         $display("FAIL %s_done: busy=%b bcd=%h expected busy=0 bcd=%h", name, busy, bcd, exp);
      end
      cur_bcd = exp;
      last_v  = val;
   endtask

   task automatic check_scan(input logic [11:0] b, input string name);
      logic [3:0] prev;
      bit synced;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      synced = 1'b0;
      prev = an;
      for (int i = 0; i < 64 && !synced; i++) begin
         step;
         if (prev == 4'b0111 && an == 4'b1110) synced = 1'b1;
         prev = an;
      end
      checks++;
      if (!synced) begin
         errors++;
         $display("FAIL %s_sync: an=%b expected 0111->1110 transition within 64 cycles", name, an);
         return;
      end
      for (int k = 0; k < 4 * RDIV; k++) begin
         if (k > 0) step;
         exp_an  = ~(4'b0001 << (k / RDIV));
         exp_seg = exp_glyph(b, k / RDIV);
         checks++;
         if (an !== exp_an || seg !== exp_seg) begin
            errors++;
            $display("FAIL %s_k%0d: an=%b seg=%h expected an=%b seg=%h", name, k, an, seg, exp_an, exp_seg);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(9'd0);
      repeat (3) step;
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || bcd !== 12'h000 || an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
         errors++;
         $display("FAIL reset: busy=%b bcd=%h an=%b seg=%h dp=%b expected 0 000 1110 40 1",
                  busy, bcd, an, seg, dp);
      end
      for (int i = 0; i < 20; i++) begin
         step;
         checks++;
         if (busy !== 1'b0 || bcd !== 12'h000) begin
            errors++;
            $display("FAIL idle_zero%0d: busy=%b bcd=%h expected 0 000", i, busy, bcd);
         end
      end
      cur_bcd = 12'h000;
      last_v  = 9'd0;
   endtask

   task automatic test_max;
      convert(9'h1FF, "max511");
   endtask

   task automatic test_seven;
      convert(9'd7, "seven");
      check_scan(12'h007, "scan007");
   endtask

   task automatic test_back_to_back;
      logic [11:0] exp;
      drive(9'd100);
      for (int i = 0; i <= 21; i++) begin
         step;
         if (i == 2) drive(9'd45);
         exp = (i < 10) ? cur_bcd : (i < 21) ? 12'h100 : 12'h045;
         checks++;
         if (bcd !== exp) begin
            errors++;
            $display("FAIL drop_e%0d: bcd=%h expected %h", i, bcd, exp);
         end
      end
      cur_bcd = 12'h045;
      last_v  = 9'd45;
   endtask

   task automatic test_scan;
      convert(9'd123, "v123");
      check_scan(12'h123, "scan123");
   endtask

   task automatic test_reset_mid;
      drive(9'd300);
      repeat (5) step;
      rst = 1'b1;
      step;
      checks++;
      if (bcd !== 12'h000 || busy !== 1'b0 || an !== 4'b1110) begin
         errors++;
         $display("FAIL midrst: bcd=%h busy=%b an=%b expected 000 0 1110", bcd, busy, an);
      end
      rst = 1'b0;
      cur_bcd = 12'h000;
      last_v  = 9'd0;
      convert(9'd300, "recap300");
   endtask

   task automatic test_random;
      logic [8:0] val;
      for (int n = 0; n < 8; n++) begin
         val = 9'($urandom_range(0, 511));
         if (val == last_v) val = val ^ 9'd1;
         convert(val, "rand");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_max;
      test_seven;
      test_back_to_back;
      test_scan;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
